// File: rtl/dreg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dreg_arbiter_pkg
//
// Shared definitions for the D-register arbiter slice:
//   NREQ      - number of requesters sharing the register bank
//   W         - width of the shared register bank
//   state_e   - arbiter FSM encoding (IDLE=0, GRANT=1, APPLY=2, ACK=3)
//   op_e      - 2-bit operation codes carried per requester
//   apply_op  - next-value function of the register bank for one operation
// ---------------------------------------------------------------------------
package dreg_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int W    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_APPLY = 2'd2,
    S_ACK   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'b00,
    OP_PRESET = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  // Value the bank takes when an operation is applied to its current contents.
  function automatic logic [W-1:0] apply_op(input op_e           code,
                                            input logic [W-1:0] cur,
                                            input logic [W-1:0] din);
    case (code)
      OP_LOAD:   return din;
      OP_PRESET: return '1;
      OP_CLEAR:  return '0;
      OP_TOGGLE: return ~cur;
      default:   return cur;
    endcase
  endfunction

endpackage : dreg_arbiter_pkg

// File: rtl/dreg_bank.sv
// ---------------------------------------------------------------------------
// dreg_bank
//
// Shared W-bit D-register bank. When we is high the bank takes the value
// selected by op on the rising edge; otherwise it holds.
//
// Ports:
//   clk  in   system clock, rising edge
//   clr  in   asynchronous active-low reset, clears the bank
//   we   in   write enable for this cycle
//   op   in   operation code (load / preset / clear / toggle)
//   d    in   load data
//   q    out  bank contents
//   q_   out  complement of q
// ---------------------------------------------------------------------------
module dreg_bank
  import dreg_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  logic         we,
  input  logic [1:0]   op,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_
);

  logic [W-1:0] bank_q;

  // NOTE: the bank is a single register word, so it is reset with the rest of
  // the state; a true RAM array would be left unreset and initialised by writes.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bank_q <= '0;
    end else if (we) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      bank_q <= apply_op(op_e'(op), bank_q, d);
    end
  end

  assign q  = bank_q;
  assign q_ = ~bank_q;

endmodule : dreg_bank

// File: rtl/dreg_arbiter.sv
// ---------------------------------------------------------------------------
// dreg_arbiter
//
// Round-robin arbiter granting NREQ requesters exclusive access to a shared
// D-register bank. A transaction runs IDLE -> GRANT -> APPLY -> ACK -> IDLE;
// the bank is written on the edge leaving APPLY and ack pulses during ACK.
// A requester that drops req while in GRANT is abandoned without a write.
//
// Ports:
//   clk    in   system clock, rising edge
//   clr    in   asynchronous active-low reset
//   req    in   per-requester level request, held until ack
//   op     in   2-bit op per requester, requester i at [2i+1:2i]
//   wdata  in   W-bit load data per requester, requester i at [Wi+W-1:Wi]
//   gnt    out  registered one-hot grant, high through GRANT/APPLY/ACK
//   ack    out  registered one-hot one-cycle completion pulse
//   q      out  shared register bank contents
//   q_     out  complement of q
//   busy   out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module dreg_arbiter #(
  parameter int NREQ = dreg_arbiter_pkg::NREQ,
  parameter int W    = dreg_arbiter_pkg::W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q,
  output logic [W-1:0]      q_,
  output logic              busy
);

  import dreg_arbiter_pkg::*;

  localparam int IDX_W = $clog2(NREQ);

  state_e            state_q;
  logic [IDX_W-1:0]  ptr_q;      // last requester that completed
  logic [IDX_W-1:0]  winner_q;   // requester owning the current transaction
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   ack_q;

  logic [IDX_W-1:0]  rr_pick;
  logic [IDX_W-1:0]  rr_cand;
  logic              rr_found;

  logic              bank_we;
  logic [1:0]        bank_op;
  logic [W-1:0]      bank_d;

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin pick: scan from ptr+1 upward, wrapping, so the requester
  // just served is examined last.
  always_comb begin
    // NOTE: every variable gets a default before the loop, otherwise a path
    // that leaves it unassigned would infer a latch.
    rr_pick  = ptr_q;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      rr_cand = IDX_W'((int'(ptr_q) + k) % NREQ);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // Arbiter FSM with registered grant and ack.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      ptr_q    <= IDX_W'(NREQ - 1);   // requester 0 has first priority
      winner_q <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rr_found) begin
            winner_q <= rr_pick;
            gnt_q    <= onehot(rr_pick);
            state_q  <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (req[winner_q]) begin
            state_q <= S_APPLY;
          end else begin
            // Withdrawn request: drop the grant, leave ptr untouched.
            gnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        S_APPLY: begin
          ack_q   <= onehot(winner_q);
          state_q <= S_ACK;
        end
        S_ACK: begin
          ack_q   <= '0;
          gnt_q   <= '0;
          ptr_q   <= winner_q;
          state_q <= S_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The bank samples the winner's op/data live, so the value present at the
  // edge leaving APPLY is the one applied.
  assign bank_we = (state_q == S_APPLY);
  assign bank_op = op[2*winner_q +: 2];
  assign bank_d  = wdata[W*winner_q +: W];

  dreg_bank u_bank (
    .clk (clk),
    .clr (clr),
    .we  (bank_we),
    .op  (bank_op),
    .d   (bank_d),
    .q   (q),
    .q_  (q_)
  );

  assign gnt  = gnt_q;
  assign ack  = ack_q;
  assign busy = (state_q != S_IDLE);

endmodule : dreg_arbiter
